// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment capture block: segment bit order,
// the sixteen hex glyphs and the capture FSM state type.
package seven_seg_pkg;

    // Segment bus layout is {a,b,c,d,e,f,g}; a is the MSB.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] GLYPH_0 = 7'h7E;
    localparam logic [6:0] GLYPH_1 = 7'h30;
    localparam logic [6:0] GLYPH_2 = 7'h6D;
    localparam logic [6:0] GLYPH_3 = 7'h79;
    localparam logic [6:0] GLYPH_4 = 7'h33;
    localparam logic [6:0] GLYPH_5 = 7'h5B;
    localparam logic [6:0] GLYPH_6 = 7'h5F;
    localparam logic [6:0] GLYPH_7 = 7'h70;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h7B;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h1F;
    localparam logic [6:0] GLYPH_C = 7'h4E;
    localparam logic [6:0] GLYPH_D = 7'h3D;
    localparam logic [6:0] GLYPH_E = 7'h4F;
    localparam logic [6:0] GLYPH_F = 7'h47;

    typedef enum logic {
        ST_WAIT   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex-glyph decoder: maps a 7-bit segment pattern to its value
// and flags any pattern that is not one of the sixteen hex glyphs.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       legal
);

    // Glyph lookup; unknown patterns report value 0 with legal low.
    always_comb begin
        value = 4'h0;
        legal = 1'b1;
        case (pattern)
            GLYPH_0: value = 4'h0;
            GLYPH_1: value = 4'h1;
            GLYPH_2: value = 4'h2;
            GLYPH_3: value = 4'h3;
            GLYPH_4: value = 4'h4;
            GLYPH_5: value = 4'h5;
            GLYPH_6: value = 4'h6;
            GLYPH_7: value = 4'h7;
            GLYPH_8: value = 4'h8;
            GLYPH_9: value = 4'h9;
            GLYPH_A: value = 4'hA;
            GLYPH_B: value = 4'hB;
            GLYPH_C: value = 4'hC;
            GLYPH_D: value = 4'hD;
            GLYPH_E: value = 4'hE;
            GLYPH_F: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a two-digit multiplexed seven-segment display after the bus settles.
// Define SEVEN_SEG_CAPTURE_TIMEOUT_EN to build the idle/stale detector.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 32768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       dsel_in,
    output logic [3:0] hi_digit,
    output logic [3:0] lo_digit,
    output logic       hi_valid,
    output logic       lo_valid,
    output logic       pair_strobe,
    output logic       bad_pattern,
    output logic       stale
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [6:0] seg_meta_q, seg_s_q;
    logic       dsel_meta_q, dsel_s_q, dsel_dly_q;
    logic       edge_s;

    state_e     state_q, state_d;
    logic [6:0] seg_ref_q, seg_ref_d;
    logic       cap_sel_q, cap_sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hi_digit_q, hi_digit_d, lo_digit_q, lo_digit_d;
    logic       hi_valid_q, hi_valid_d, lo_valid_q, lo_valid_d;
    logic       pair_strobe_q, pair_strobe_d, bad_pattern_q, bad_pattern_d;
    logic [3:0] dec_value_s;
    logic       dec_legal_s;

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    logic [15:0] idle_q, idle_d;
    logic        stale_q, stale_d;
`endif

    seven_seg_decode u_decode (
        .pattern (seg_ref_q),
        .value   (dec_value_s),
        .legal   (dec_legal_s)
    );

    assign edge_s = dsel_s_q ^ dsel_dly_q;

    // Next-state logic: restart on any select edge, otherwise settle and capture.
    always_comb begin
        state_d       = state_q;
        seg_ref_d     = seg_ref_q;
        cap_sel_d     = cap_sel_q;
        cnt_d         = cnt_q;
        hi_digit_d    = hi_digit_q;
        lo_digit_d    = lo_digit_q;
        hi_valid_d    = hi_valid_q;
        lo_valid_d    = lo_valid_q;
        pair_strobe_d = 1'b0;
        bad_pattern_d = 1'b0;
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
        stale_d = stale_q;
        if (edge_s) begin
            idle_d = 16'h0000;
        end else if (idle_q != 16'hFFFF) begin
            idle_d = idle_q + 16'h0001;
        end else begin
            idle_d = idle_q;
        end
        if (idle_q == TIMEOUT_C) begin
            stale_d    = 1'b1;
            hi_valid_d = 1'b0;
            lo_valid_d = 1'b0;
        end else begin
            stale_d = stale_d;
        end
`endif
        if (edge_s) begin
            seg_ref_d = seg_s_q;
            cap_sel_d = dsel_s_q;
            cnt_d     = 8'h00;
            state_d   = ST_SETTLE;
        end else if (state_q == ST_SETTLE) begin
            if (seg_s_q != seg_ref_q) begin
                seg_ref_d = seg_s_q;
                cnt_d     = 8'h00;
            end else if (cnt_q == SETTLE_LAST) begin
                state_d = ST_WAIT;
                cnt_d   = 8'h00;
                if (!dec_legal_s) begin
                    bad_pattern_d = 1'b1;
                    if (cap_sel_q) begin
                        hi_valid_d = 1'b0;
                    end else begin
                        lo_valid_d = 1'b0;
                    end
                end else begin
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
                    stale_d = 1'b0;
`endif
                    if (cap_sel_q) begin
                        hi_digit_d = dec_value_s;
                        hi_valid_d = 1'b1;
                    end else begin
                        lo_digit_d    = dec_value_s;
                        lo_valid_d    = 1'b1;
                        pair_strobe_d = hi_valid_q;
                    end
                end
            end else begin
                cnt_d = cnt_q + 8'h01;
            end
        end else begin
            state_d = ST_WAIT;
        end
    end

    // Synchronizers, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_meta_q    <= 7'h00;
            seg_s_q       <= 7'h00;
            dsel_meta_q   <= 1'b0;
            dsel_s_q      <= 1'b0;
            dsel_dly_q    <= 1'b0;
            state_q       <= ST_WAIT;
            seg_ref_q     <= 7'h00;
            cap_sel_q     <= 1'b0;
            cnt_q         <= 8'h00;
            hi_digit_q    <= 4'h0;
            lo_digit_q    <= 4'h0;
            hi_valid_q    <= 1'b0;
            lo_valid_q    <= 1'b0;
            pair_strobe_q <= 1'b0;
            bad_pattern_q <= 1'b0;
        end else begin
            seg_meta_q    <= seg_in;
            seg_s_q       <= seg_meta_q;
            dsel_meta_q   <= dsel_in;
            dsel_s_q      <= dsel_meta_q;
            dsel_dly_q    <= dsel_s_q;
            state_q       <= state_d;
            seg_ref_q     <= seg_ref_d;
            cap_sel_q     <= cap_sel_d;
            cnt_q         <= cnt_d;
            hi_digit_q    <= hi_digit_d;
            lo_digit_q    <= lo_digit_d;
            hi_valid_q    <= hi_valid_d;
            lo_valid_q    <= lo_valid_d;
            pair_strobe_q <= pair_strobe_d;
            bad_pattern_q <= bad_pattern_d;
        end
    end

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    // Idle counter and stale flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q  <= 16'h0000;
            stale_q <= 1'b0;
        end else begin
            idle_q  <= idle_d;
            stale_q <= stale_d;
        end
    end
    assign stale = stale_q;
`else
    assign stale = 1'b0;
`endif

    assign hi_digit    = hi_digit_q;
    assign lo_digit    = lo_digit_q;
    assign hi_valid    = hi_valid_q;
    assign lo_valid    = lo_valid_q;
    assign pair_strobe = pair_strobe_q;
    assign bad_pattern = bad_pattern_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of single-digit captures plus
// hand-written latency, glitch, reset-abort and idle-timeout sequences.
module tb_seven_seg_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       dsel_in;
    logic [3:0] hi_digit, lo_digit;
    logic       hi_valid, lo_valid, pair_strobe, bad_pattern, stale;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_cnt  = 0;
    int pair_cnt = 0;
    int b0, p0;

    typedef struct {
        logic [6:0] seg;
        logic       sel;
        logic [3:0] digit;
        logic       valid;
        int         bad;
        int         pair;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
    seven_seg_capture #(.SETTLE(4), .TIMEOUT(100)) dut (
`else
    seven_seg_capture #(.SETTLE(4)) dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dsel_in     (dsel_in),
        .hi_digit    (hi_digit),
        .lo_digit    (lo_digit),
        .hi_valid    (hi_valid),
        .lo_valid    (lo_valid),
        .pair_strobe (pair_strobe),
        .bad_pattern (bad_pattern),
        .stale       (stale)
    );

    always @(negedge clk) begin
        if (bad_pattern) bad_cnt++;
        if (pair_strobe) pair_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {15'h0, hi_digit, lo_digit, hi_valid, lo_valid, pair_strobe, bad_pattern, stale};
    endfunction

    initial begin
        vecs[0]  = '{7'h7E, 1'b1, 4'h0, 1'b1, 0, 0};
        vecs[1]  = '{7'h30, 1'b0, 4'h1, 1'b1, 0, 1};
        vecs[2]  = '{7'h5B, 1'b1, 4'h5, 1'b1, 0, 0};
        vecs[3]  = '{7'h77, 1'b0, 4'hA, 1'b1, 0, 1};
        vecs[4]  = '{7'h01, 1'b1, 4'h5, 1'b0, 1, 0};
        vecs[5]  = '{7'h47, 1'b0, 4'hF, 1'b1, 0, 0};
        vecs[6]  = '{7'h3D, 1'b1, 4'hD, 1'b1, 0, 0};
        vecs[7]  = '{7'h01, 1'b0, 4'hF, 1'b0, 1, 0};
        vecs[8]  = '{7'h70, 1'b1, 4'h7, 1'b1, 0, 0};
        vecs[9]  = '{7'h1F, 1'b0, 4'hB, 1'b1, 0, 1};
        vecs[10] = '{7'h7F, 1'b1, 4'h8, 1'b1, 0, 0};
        vecs[11] = '{7'h33, 1'b0, 4'h4, 1'b1, 0, 1};
        vecs[12] = '{7'h4E, 1'b1, 4'hC, 1'b1, 0, 0};
        vecs[13] = '{7'h5F, 1'b0, 4'h6, 1'b1, 0, 1};
        vecs[14] = '{7'h79, 1'b1, 4'h3, 1'b1, 0, 0};
        vecs[15] = '{7'h7B, 1'b0, 4'h9, 1'b1, 0, 1};

        rst = 1'b1; seg_in = 7'h00; dsel_in = 1'b0;
        step(3);
        check("reset_outs", all_outs(), 32'h0);
        rst = 1'b0;
        step(2);
        check("post_reset_outs", all_outs(), 32'h0);

        // High digit 2: valid exactly 7 clock edges after the pin change.
        seg_in = 7'h6D; dsel_in = 1'b1;
        step(6);
        check("hi_latency_early", {31'h0, hi_valid}, 32'h0);
        step(1);
        check("hi_latency_valid", {31'h0, hi_valid}, 32'h1);
        check("hi_latency_digit", {28'h0, hi_digit}, 32'h2);
        step(3);

        // Low digit E completes a pair.
        p0 = pair_cnt;
        seg_in = 7'h4F; dsel_in = 1'b0;
        step(6);
        check("lo_latency_early", {31'h0, lo_valid}, 32'h0);
        step(1);
        check("lo_latency_valid", {31'h0, lo_valid}, 32'h1);
        check("lo_latency_digit", {28'h0, lo_digit}, 32'hE);
        step(3);
        check("pair_first", pair_cnt - p0, 32'h1);
        check("hi_kept", {28'h0, hi_digit}, 32'h2);

        for (int i = 0; i < 16; i++) begin
            b0 = bad_cnt; p0 = pair_cnt;
            seg_in = vecs[i].seg; dsel_in = vecs[i].sel;
            step(12);
            check($sformatf("vec%0d_digit", i), {28'h0, vecs[i].sel ? hi_digit : lo_digit}, {28'h0, vecs[i].digit});
            check($sformatf("vec%0d_valid", i), {31'h0, vecs[i].sel ? hi_valid : lo_valid}, {31'h0, vecs[i].valid});
            check($sformatf("vec%0d_bad", i), bad_cnt - b0, vecs[i].bad);
            check($sformatf("vec%0d_pair", i), pair_cnt - p0, vecs[i].pair);
        end

        // Glitching bus after a select edge: settle counts from the last change.
        b0 = bad_cnt;
        seg_in = 7'h30; dsel_in = 1'b1;
        step(1);
        seg_in = 7'h7F;
        step(1);
        seg_in = 7'h30;
        step(6);
        check("glitch_no_early", {28'h0, hi_digit}, 32'h3);
        step(1);
        check("glitch_digit", {28'h0, hi_digit}, 32'h1);
        check("glitch_valid", {31'h0, hi_valid}, 32'h1);
        step(5);
        check("glitch_digit_hold", {28'h0, hi_digit}, 32'h1);
        check("glitch_no_bad", bad_cnt - b0, 32'h0);

        // Reset two cycles into SETTLE abandons the capture.
        seg_in = 7'h6D; dsel_in = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        check("rst_mid_outs", all_outs(), 32'h0);
        rst = 1'b0;
        step(1);
        check("rst_mid_after", all_outs(), 32'h0);
        step(10);
        check("rst_mid_no_capture", all_outs(), 32'h0);

        // Reset with select held high: an edge appears once the synchronizer fills.
        seg_in = 7'h5B; dsel_in = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);
        check("rst_sel_hi_early", {31'h0, hi_valid}, 32'h0);
        step(1);
        check("rst_sel_hi_valid", {31'h0, hi_valid}, 32'h1);
        check("rst_sel_hi_digit", {28'h0, hi_digit}, 32'h5);
        check("rst_sel_lo_valid", {31'h0, lo_valid}, 32'h0);

        // Idle timeout behaviour.
        p0 = pair_cnt;
        seg_in = 7'h7E; dsel_in = 1'b0;
        step(12);
        check("to_lo_valid", {31'h0, lo_valid}, 32'h1);
        check("to_lo_pair", pair_cnt - p0, 32'h1);
        step(80);
        check("to_not_yet", {29'h0, stale, hi_valid, lo_valid}, 32'h3);
        step(20);
`ifdef SEVEN_SEG_CAPTURE_TIMEOUT_EN
        check("to_stale", {29'h0, stale, hi_valid, lo_valid}, 32'h4);
`else
        check("to_stale", {29'h0, stale, hi_valid, lo_valid}, 32'h3);
`endif
        seg_in = 7'h30; dsel_in = 1'b1;
        step(12);
        check("to_clear_stale", {31'h0, stale}, 32'h0);
        check("to_clear_hi", {27'h0, hi_valid, hi_digit}, 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
